// File: rtl/qif_pkg.sv
// qif_pkg: default dynamics constants, saturation helper and spike event type
// shared by the QIF neuron array and its update datapath.
// Optional feature macro used by the including files: QIF_REFRACTORY_EN.
package qif_pkg;

  localparam int QIF_BSHIFT = 2;
  localparam int QIF_QSHIFT = 4;
  localparam int QIF_VPEAK  = 50;
  localparam int QIF_VRESET = -20;

  // Widest channel index an event can carry; arrays up to 256 channels.
  localparam int QIF_EVT_CW = 8;

  typedef struct packed {
    logic                  valid;
    logic [QIF_EVT_CW-1:0] chan;
  } qif_evt_t;

  // Clamp x to the range of a w-bit two's-complement number (w <= 63).
  function automatic logic signed [63:0] sat_W(input logic signed [63:0] x, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/qif_update.sv
// qif_update: combinational per-visit QIF datapath shared by all channels.
// Priority: refractory clamp (QIF_REFRACTORY_EN only), spike, integrate.
// Integration runs at 2W+2 signed bits so V*V never overflows before saturation.
module qif_update
  import qif_pkg::*;
#(
  parameter int W      = 8,
  parameter int BSHIFT = QIF_BSHIFT,
  parameter int QSHIFT = QIF_QSHIFT,
  parameter int VPEAK  = QIF_VPEAK,
  parameter int VRESET = QIF_VRESET
`ifdef QIF_REFRACTORY_EN
  ,
  parameter int REFRAC = 3,
  parameter int RCW    = 2
`endif
) (
  input  logic signed [W-1:0]   i_v,
  input  logic signed [W-1:0]   i_b,
`ifdef QIF_REFRACTORY_EN
  input  logic        [RCW-1:0] i_rcnt,
  output logic        [RCW-1:0] o_rcnt_next,
`endif
  output logic signed [W-1:0]   o_v_next,
  output logic                  o_spike
);

  localparam int SW = 2 * W + 2;

  logic signed [SW-1:0] w_v;
  logic signed [SW-1:0] w_sum;

  assign w_v   = SW'(i_v);
  assign w_sum = w_v + (SW'(i_b) >>> BSHIFT) + ((w_v * w_v) >>> QSHIFT);

  // Select next V (and refractory count) for the visited channel.
  always_comb begin
    o_spike  = 1'b0;
    o_v_next = W'(sat_W(64'(w_sum), W));
`ifdef QIF_REFRACTORY_EN
    o_rcnt_next = i_rcnt;
    if (i_rcnt != '0) begin
      o_v_next    = W'(VRESET);
      o_rcnt_next = i_rcnt - RCW'(1);
    end else if (i_v >= W'(VPEAK)) begin
      o_v_next    = W'(VRESET);
      o_rcnt_next = RCW'(REFRAC);
      o_spike     = 1'b1;
    end
`else
    if (i_v >= W'(VPEAK)) begin
      o_v_next = W'(VRESET);
      o_spike  = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/qif_neuron_array.sv
// qif_neuron_array: N_CHAN time-multiplexed QIF neurons, one channel updated
// per enabled cycle in round-robin order, spikes emitted as (valid, chan).
// Define QIF_REFRACTORY_EN to hold a spiking channel at VRESET for REFRAC visits.
module qif_neuron_array
  import qif_pkg::*;
#(
  parameter int N_CHAN = 4,
  parameter int W      = 8,
  parameter int BSHIFT = QIF_BSHIFT,
  parameter int QSHIFT = QIF_QSHIFT,
  parameter int VPEAK  = QIF_VPEAK,
  parameter int VRESET = QIF_VRESET,
  parameter int REFRAC = 3,
  localparam int CW    = $clog2(N_CHAN)
) (
  input  logic                clk,
  input  logic                rst_n,   // active-high synchronous reset
  input  logic                ena,
  input  logic                b_we,
  input  logic [CW-1:0]       b_addr,
  input  logic signed [W-1:0] b_data,
  output logic                spike_valid,
  output logic [CW-1:0]       spike_chan,
  output logic                frame_done,
  input  logic [CW-1:0]       v_sel,
  output logic signed [W-1:0] v_out
);

`ifdef QIF_REFRACTORY_EN
  localparam int RCW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  logic [N_CHAN-1:0][RCW-1:0] r_rcnt;
  logic [RCW-1:0]             w_rcnt_next;
`endif

  logic [N_CHAN-1:0][W-1:0] r_v;
  logic [N_CHAN-1:0][W-1:0] r_b;
  logic [CW-1:0]            r_ptr;
  logic signed [W-1:0]      w_v_next;
  logic                     w_spike;
  logic                     w_last;
  qif_evt_t                 w_evt;

  logic                     r_spike_valid;
  logic [CW-1:0]            r_spike_chan;
  logic                     r_frame_done;
  logic signed [W-1:0]      r_v_out;

  qif_update #(
    .W(W), .BSHIFT(BSHIFT), .QSHIFT(QSHIFT), .VPEAK(VPEAK), .VRESET(VRESET)
`ifdef QIF_REFRACTORY_EN
    , .REFRAC(REFRAC), .RCW(RCW)
`endif
  ) u_update (
    .i_v         (r_v[r_ptr]),
    .i_b         (r_b[r_ptr]),
`ifdef QIF_REFRACTORY_EN
    .i_rcnt      (r_rcnt[r_ptr]),
    .o_rcnt_next (w_rcnt_next),
`endif
    .o_v_next    (w_v_next),
    .o_spike     (w_spike)
  );

  assign w_evt  = '{valid: ena & w_spike, chan: QIF_EVT_CW'(r_ptr)};
  assign w_last = (w_evt.chan == QIF_EVT_CW'(N_CHAN - 1));

  // Commit the visited channel's state and advance the round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N_CHAN; i++) r_v[i] <= W'(VRESET);
`ifdef QIF_REFRACTORY_EN
      r_rcnt <= '0;
`endif
      r_ptr <= '0;
    end else if (ena) begin
      r_v[r_ptr] <= w_v_next;
`ifdef QIF_REFRACTORY_EN
      r_rcnt[r_ptr] <= w_rcnt_next;
`endif
      r_ptr <= w_last ? '0 : r_ptr + CW'(1);
    end
  end

  // Host drive writes; a same-cycle visit has already read the old value.
  always_ff @(posedge clk) begin
    if (rst_n)     r_b <= '0;
    else if (b_we) r_b[b_addr] <= b_data;
  end

  // Registered event, frame marker and monitor read (sees same-cycle update).
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_spike_valid <= 1'b0;
      r_spike_chan  <= '0;
      r_frame_done  <= 1'b0;
      r_v_out       <= W'(VRESET);
    end else begin
      r_spike_valid <= w_evt.valid;
      if (w_evt.valid) r_spike_chan <= r_ptr;
      r_frame_done  <= ena & w_last;
      r_v_out       <= (ena && v_sel == r_ptr) ? w_v_next : r_v[v_sel];
    end
  end

  assign spike_valid = r_spike_valid;
  assign spike_chan  = r_spike_chan;
  assign frame_done  = r_frame_done;
  assign v_out       = r_v_out;

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb_qif_neuron_array: directed plus randomized checks of qif_neuron_array
// against an integer reference model of the neuron rules.
// Honours QIF_REFRACTORY_EN in the same way as the design.
module tb_qif_neuron_array;

  localparam int N   = 4;
  localparam int W   = 8;
  localparam int BSH = 2;
  localparam int QSH = 4;
  localparam int VPK = 50;
  localparam int VRS = -20;
  localparam int RF  = 3;
  localparam int VMAX = (1 << (W - 1)) - 1;
  localparam int VMIN = -(1 << (W - 1));

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ena;
  logic              b_we;
  logic [1:0]        b_addr;
  logic signed [7:0] b_data;
  logic              spike_valid;
  logic [1:0]        spike_chan;
  logic              frame_done;
  logic [1:0]        v_sel;
  logic signed [7:0] v_out;

  int checks = 0;
  int errors = 0;

  // reference model state and expected registered outputs
  int mv[N];
  int mb[N];
  int mr[N];
  int mptr;
  int e_sv, e_sc, e_fd, e_vo;
  int seq[7] = '{5, 6, 8, 12, 21, 48, 127};
  logic signed [7:0] held_v;

  qif_neuron_array #(
    .N_CHAN(N), .W(W), .BSHIFT(BSH), .QSHIFT(QSH),
    .VPEAK(VPK), .VRESET(VRS), .REFRAC(RF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .b_we(b_we), .b_addr(b_addr),
    .b_data(b_data), .spike_valid(spike_valid), .spike_chan(spike_chan),
    .frame_done(frame_done), .v_sel(v_sel), .v_out(v_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic signed [31:0] got, logic signed [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock edge of the neuron rules, applied to the inputs seen at that edge.
  task automatic model_edge();
    int c;
    int s;
    bit spk;
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin mv[i] = VRS; mb[i] = 0; mr[i] = 0; end
      mptr = 0; e_sv = 0; e_sc = 0; e_fd = 0; e_vo = VRS;
      return;
    end
    spk = 0;
    c   = mptr;
    if (ena) begin
`ifdef QIF_REFRACTORY_EN
      if (mr[c] > 0) begin mv[c] = VRS; mr[c] = mr[c] - 1; end else
`endif
      if (mv[c] >= VPK) begin mv[c] = VRS; mr[c] = RF; spk = 1; end
      else begin
        s = mv[c] + (mb[c] >>> BSH) + ((mv[c] * mv[c]) >>> QSH);
        mv[c] = (s > VMAX) ? VMAX : (s < VMIN) ? VMIN : s;
      end
      mptr = (mptr + 1) % N;
    end
    if (b_we) mb[b_addr] = b_data;
    e_sv = spk;
    if (spk) e_sc = c;
    e_fd = (ena && c == N - 1) ? 1 : 0;
    e_vo = mv[v_sel];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("spike_valid", spike_valid, e_sv);
    chk("spike_chan", spike_chan, e_sc);
    chk("frame_done", frame_done, e_fd);
    chk("v_out", v_out, e_vo);
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    rst_n = 1'b1; ena = 1'b0; b_we = 1'b0; b_addr = '0; b_data = '0; v_sel = '0;

    // reset values
    run(2);
    chk("rst_spike_valid", spike_valid, 0);
    chk("rst_spike_chan", spike_chan, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_v_out", v_out, VRS);

    // B=0 everywhere: channel 0 trajectory and spike at edge 29
    rst_n = 1'b0; ena = 1'b1;
    for (int e = 1; e <= 29; e++) begin
      step();
      if (e % 4 == 1 && e <= 25) chk("ch0_traj", v_out, seq[(e - 1) / 4]);
      if (e == 4) chk("first_frame", frame_done, 1);
    end
    chk("spike0_valid", spike_valid, 1);
    chk("spike0_chan", spike_chan, 0);
    chk("spike0_v", v_out, VRS);
    step();   // channel 1 spikes right behind channel 0
    chk("spike1_valid", spike_valid, 1);
    chk("spike1_chan", spike_chan, 1);
    run(3);   // edge 33: first post-spike visit of channel 0
`ifdef QIF_REFRACTORY_EN
    chk("refrac_1", v_out, VRS);
    run(4); chk("refrac_2", v_out, VRS);
    run(4); chk("refrac_3", v_out, VRS);
    run(4); chk("refrac_end", v_out, 5);
`else
    chk("post_spike", v_out, 5);
`endif

    // hold with ena low
    run(2);
    held_v = v_out;
    ena = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("hold_sv", spike_valid, 0);
      chk("hold_fd", frame_done, 0);
      chk("hold_v", v_out, held_v);
    end
    ena = 1'b1;
    run(8);

    // write/visit collision on channel 2
    rst_n = 1'b1; step();
    rst_n = 1'b0; v_sel = 2'd2;
    run(2);
    b_we = 1'b1; b_addr = 2'd2; b_data = -8'sd128;
    step();
    chk("collide_old_b", v_out, 5);
    b_we = 1'b0;
    run(4);
    chk("collide_new_b", v_out, -26);

    // reset on the spike-detecting edge drops the event
    rst_n = 1'b1; step();
    rst_n = 1'b0; v_sel = 2'd0;
    run(28);
    chk("pre_spike_v", v_out, 127);
    rst_n = 1'b1; step();
    chk("rst_mid_sv", spike_valid, 0);
    chk("rst_mid_sc", spike_chan, 0);
    chk("rst_mid_fd", frame_done, 0);
    chk("rst_mid_v", v_out, VRS);
    rst_n = 1'b0;

    // randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rst_n  = ($urandom_range(0, 149) == 0);
      ena    = ($urandom_range(0, 7) != 0);
      b_we   = ($urandom_range(0, 2) == 0);
      b_addr = 2'($urandom_range(0, N - 1));
      b_data = 8'($urandom);
      v_sel  = 2'($urandom_range(0, N - 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
